copro_dispatch: RTL and testbench
=================================

Name: copro_dispatch

Overview:
- Sits between the LM32 user-instruction (coprocessor) port and up to NUM_UNITS floating-point/arith coprocessor units.
- Decodes the unit-select field of the opcode, latches the operands and issues the operation to exactly one unit.
- Waits for that unit's completion and returns its result to the CPU.
- Holds sticky error flags for a bad unit select and, optionally, a unit timeout.

Parameters:
- NUM_UNITS, 4, number of attached units (1..8).
- SEL_LSB, 8, LSB of the 3-bit unit-select field cpu_opcode[SEL_LSB+2:SEL_LSB].
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_valid  in  1  CPU op request; held high until cpu_complete
- cpu_opcode  in  11  user opcode
- cpu_op0  in  32  operand 0
- cpu_op1  in  32  operand 1
- cpu_result  out  32  registered result
- cpu_complete  out  1  one-cycle completion pulse
- unit_valid  out  NUM_UNITS  one-hot issue strobe, level until that unit completes
- unit_opcode  out  11  latched opcode, shared by all units
- unit_op0  out  32  latched operand 0, shared
- unit_op1  out  32  latched operand 1, shared
- unit_result  in  32*NUM_UNITS  packed results, unit i at [32*i+31:32*i]
- unit_complete  in  NUM_UNITS  per-unit one-cycle done pulse
- err_clr  in  1  clears sticky errors
- err  out  2  sticky flags: [0] bad select, [1] timeout
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; all of the following are 0: unit_valid, cpu_complete, cpu_result, unit_opcode, unit_op0, unit_op1, err. Reset mid-operation aborts immediately; a late unit_complete is then ignored.
- IDLE:
  - On cpu_valid=1, latch opcode/op0/op1 and sel = cpu_opcode[SEL_LSB+2:SEL_LSB].
  - If sel < NUM_UNITS, go to WAIT with unit_valid[sel]=1 on the next cycle.
  - Otherwise go to ERR.
- WAIT:
  - unit_valid[sel] is held.
  - On unit_complete[sel]=1, capture unit_result[sel] into cpu_result, drop unit_valid and go to DONE.
  - unit_complete from a non-selected unit is ignored.
- ERR: cpu_result = 32'h0, err[0] is set, go to DONE.
- DONE: cpu_complete=1 for exactly one cycle, then go to DRAIN.
- DRAIN: wait for cpu_valid=0, then go to IDLE. This prevents reissue of the same request.
- Latency:
  - cpu_valid sampled at cycle 0 gives unit_valid at cycle 1.
  - unit_complete at cycle k gives cpu_complete at cycle k+1.
  - Bad select gives cpu_complete at cycle 2.
- cpu_result holds its value until the next capture.
- Outputs unit_opcode, unit_op0 and unit_op1 are stable from issue until the next accept.
- err bits are sticky until err_clr. If err_clr and a set event occur in the same cycle, set wins.
- unit_complete[sel] in the same cycle as unit_valid first rises is legal and is accepted (zero-latency unit).

Optional Feature:
- Macro: COPRO_TIMEOUT_EN.
- Enabled:
  - A counter of width $clog2(TIMEOUT_CYCLES)+1 clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES: drop unit_valid, set cpu_result = 32'hFFFF_FFFF, set err[1], go to DONE.
  - If unit_complete[sel] arrives in the same cycle as the limit, the completion wins.
- Disabled: no counter, err[1] is tied to 0, and WAIT can last indefinitely.

Decomposition:
- Package copro_pkg:
  - state enum {IDLE, WAIT, ERR, DONE, DRAIN}.
  - Constants SEL_W=3, OPC_W=11, DATA_W=32, ERR_BAD_SEL=0, ERR_TIMEOUT=1.
  - Result constants RES_BAD=32'h0, RES_TMO=32'hFFFF_FFFF.
- Sub-module copro_watchdog (counter, clear, expire), instantiated only under COPRO_TIMEOUT_EN.

Test Plan:
- Basic issue to unit 1:
  - Stimulus: opcode=11'h105, op0=32'h3F80_0000, op1=32'h4000_0000; unit 1 completes 3 cycles after issue with 32'h4040_0000.
  - Response: unit_valid=4'b0010 for exactly cycles 1..3; cpu_result=32'h4040_0000 with cpu_complete at cycle 4; busy low after cpu_valid drops.
- Bad select:
  - Stimulus: NUM_UNITS=4, opcode=11'h600.
  - Response: unit_valid never asserts; cpu_complete at cycle 2 with result 0; err=2'b01; err_clr pulse returns err to 0.
- Spurious completion:
  - Stimulus: unit 2 selected; unit 0 pulses complete with 32'hDEAD_BEEF at cycle 2, then unit 2 completes with 32'h1234_5678.
  - Response: cpu_result=32'h1234_5678 only.
- Valid held after complete:
  - Stimulus: cpu_valid kept high 5 cycles after cpu_complete.
  - Response: no second unit_valid until cpu_valid falls and then rises again.
- Reset mid-operation:
  - Stimulus: rst during WAIT, then unit completes 1 cycle later.
  - Response: all outputs 0, no cpu_complete, next op works normally.
- Timeout (COPRO_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: unit never completes.
  - Response: cpu_complete 17 cycles after accept, result 32'hFFFF_FFFF, err=2'b10.
  - Tie case: completion arriving at the limit cycle returns the unit's result and err stays 0.

Source files
------------

// File: rtl/copro_pkg.sv
// Shared types and constants for the LM32 coprocessor dispatcher.
// Optional unit watchdog is enabled with the COPRO_TIMEOUT_EN macro.
package copro_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ERR,
    DONE,
    DRAIN
  } state_t;

  localparam int SEL_W       = 3;
  localparam int OPC_W       = 11;
  localparam int DATA_W      = 32;
  localparam int ERR_BAD_SEL = 0;
  localparam int ERR_TIMEOUT = 1;

  localparam logic [DATA_W-1:0] RES_BAD = 32'h0000_0000;
  localparam logic [DATA_W-1:0] RES_TMO = 32'hFFFF_FFFF;

endpackage

// File: rtl/copro_dispatch_if.sv
// CPU user-instruction port plus shared coprocessor unit bus.
// slave = dispatcher view, master = environment (CPU and units) view.
interface copro_dispatch_if #(
  parameter int NUM_UNITS = 4
);
  import copro_pkg::*;

  logic                        cpu_valid;
  logic [OPC_W-1:0]            cpu_opcode;
  logic [DATA_W-1:0]           cpu_op0;
  logic [DATA_W-1:0]           cpu_op1;
  logic [DATA_W-1:0]           cpu_result;
  logic                        cpu_complete;

  logic [NUM_UNITS-1:0]        unit_valid;
  logic [OPC_W-1:0]            unit_opcode;
  logic [DATA_W-1:0]           unit_op0;
  logic [DATA_W-1:0]           unit_op1;
  logic [DATA_W*NUM_UNITS-1:0] unit_result;
  logic [NUM_UNITS-1:0]        unit_complete;

  modport slave (
    input  cpu_valid, cpu_opcode, cpu_op0, cpu_op1, unit_result, unit_complete,
    output cpu_result, cpu_complete, unit_valid, unit_opcode, unit_op0, unit_op1
  );

  modport master (
    output cpu_valid, cpu_opcode, cpu_op0, cpu_op1, unit_result, unit_complete,
    input  cpu_result, cpu_complete, unit_valid, unit_opcode, unit_op0, unit_op1
  );

endinterface

// File: rtl/copro_watchdog.sv
// Cycle counter for the WAIT state; expire fires on the LIMIT-th counted cycle.
// Only instantiated when COPRO_TIMEOUT_EN is defined.
module copro_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CntW = $clog2(LIMIT) + 1;

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (count_en) begin
      cnt <= cnt + CntW'(1);
    end
  end

  // The current cycle counts, so the limit is hit while cnt still reads LIMIT-1.
  assign expire = count_en && ((cnt + CntW'(1)) == CntW'(LIMIT));

endmodule

// File: rtl/copro_dispatch.sv
// Routes LM32 user instructions to one of NUM_UNITS coprocessors and returns the result.
// Define COPRO_TIMEOUT_EN to build the per-operation unit watchdog.
module copro_dispatch
  import copro_pkg::*;
#(
  parameter int NUM_UNITS      = 4,
  parameter int SEL_LSB        = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  copro_dispatch_if.slave     bus,
  input  logic                err_clr,
  output logic [1:0]          err,
  output logic                busy
);

  state_t               state;
  state_t               state_nxt;
  logic [SEL_W-1:0]     cpu_sel;
  logic                 sel_ok;
  logic [SEL_W-1:0]     sel_q;
  logic [OPC_W-1:0]     opc_q;
  logic [DATA_W-1:0]    op0_q;
  logic [DATA_W-1:0]    op1_q;
  logic [DATA_W-1:0]    res_q;
  logic [1:0]           err_q;
  logic [1:0]           err_set;
  logic [NUM_UNITS-1:0] sel_mask;
  logic [DATA_W-1:0]    res_sel;
  logic                 sel_done;
  logic                 tmo_expire;

  assign cpu_sel = bus.cpu_opcode[SEL_LSB +: SEL_W];
  assign sel_ok  = int'(cpu_sel) < NUM_UNITS;

  always_comb begin
    sel_mask = '0;
    res_sel  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_mask[i] = 1'b1;
        res_sel     = bus.unit_result[DATA_W*i +: DATA_W];
      end
    end
  end

  // Completions from units other than the latched one never reach the FSM.
  assign sel_done = |(bus.unit_complete & sel_mask);

`ifdef COPRO_TIMEOUT_EN
  copro_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (state != WAIT),
    .count_en (state == WAIT),
    .expire   (tmo_expire)
  );
`else
  logic unused_tmo_limit;
  assign unused_tmo_limit = ^TIMEOUT_CYCLES;
  assign tmo_expire       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cpu_valid) state_nxt = sel_ok ? WAIT : ERR;
      WAIT:    if (sel_done || tmo_expire) state_nxt = DONE;
      ERR:     state_nxt = DONE;
      DONE:    state_nxt = DRAIN;
      DRAIN:   if (!bus.cpu_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    err_set              = '0;
    err_set[ERR_BAD_SEL] = (state == ERR);
    err_set[ERR_TIMEOUT] = (state == WAIT) && !sel_done && tmo_expire;
  end

  // Operand latches and result register; a real completion beats a same-cycle timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= '0;
      opc_q <= '0;
      op0_q <= '0;
      op1_q <= '0;
      res_q <= '0;
      err_q <= '0;
    end else begin
      if (state == IDLE && bus.cpu_valid) begin
        sel_q <= cpu_sel;
        opc_q <= bus.cpu_opcode;
        op0_q <= bus.cpu_op0;
        op1_q <= bus.cpu_op1;
      end
      if (state == WAIT && sel_done) begin
        res_q <= res_sel;
      end else if (state == WAIT && tmo_expire) begin
        res_q <= RES_TMO;
      end else if (state == ERR) begin
        res_q <= RES_BAD;
      end
      err_q <= (err_q & ~{2{err_clr}}) | err_set;
    end
  end

  assign bus.unit_valid   = (state == WAIT) ? sel_mask : '0;
  assign bus.unit_opcode  = opc_q;
  assign bus.unit_op0     = op0_q;
  assign bus.unit_op1     = op1_q;
  assign bus.cpu_result   = res_q;
  assign bus.cpu_complete = (state == DONE);
  assign err              = err_q;
  assign busy             = (state != IDLE);

endmodule

// File: tb/tb_copro_dispatch.sv
// Directed self-checking bench for copro_dispatch; covers the watchdog when
// COPRO_TIMEOUT_EN is defined, otherwise an indefinitely long WAIT.
module tb_copro_dispatch;
  import copro_pkg::*;

  localparam int NUM_UNITS      = 4;
  localparam int SEL_LSB        = 8;
  localparam int TIMEOUT_CYCLES = 16;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       err_clr = 1'b0;
  logic [1:0] err;
  logic       busy;

  int n_compared   = 0;
  int n_mismatched = 0;

  copro_dispatch_if #(.NUM_UNITS(NUM_UNITS)) bus ();

  copro_dispatch #(
    .NUM_UNITS      (NUM_UNITS),
    .SEL_LSB        (SEL_LSB),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_clr (err_clr),
    .err     (err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [10:0] opcode,
                               input logic [31:0] op0, input logic [31:0] op1);
    bus.cpu_valid  = valid;
    bus.cpu_opcode = opcode;
    bus.cpu_op0    = op0;
    bus.cpu_op1    = op1;
  endtask

  task automatic unitDone(input int unit, input logic [31:0] value);
    bus.unit_complete                = NUM_UNITS'(1) << unit;
    bus.unit_result[32*unit +: 32]   = value;
  endtask

  task automatic unitIdle();
    bus.unit_complete = '0;
  endtask

  // Bad select from IDLE with err starting at 0; returns in the following IDLE cycle.
  task automatic runBadSelect(input logic [10:0] opcode, input string tag);
    applyStimulus(1'b1, opcode, 32'h1111_1111, 32'h2222_2222);
    for (int c = 1; c <= 4; c++) begin
      waitCycle();
      checkOutput($sformatf("%s_uv_c%0d", tag, c), 32'(bus.unit_valid), 32'h0);
      checkOutput($sformatf("%s_cc_c%0d", tag, c), 32'(bus.cpu_complete), 32'(c == 2));
      checkOutput($sformatf("%s_err_c%0d", tag, c), 32'(err), (c >= 2) ? 32'h1 : 32'h0);
      checkOutput($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(c <= 3));
      if (c == 2) checkOutput($sformatf("%s_result", tag), bus.cpu_result, 32'h0);
      if (c == 3) bus.cpu_valid = 1'b0;
    end
  endtask

  initial begin
    applyStimulus(1'b0, 11'h0, 32'h0, 32'h0);
    bus.unit_result   = '0;
    bus.unit_complete = '0;
    rst = 1'b1;
    waitCycle();
    waitCycle();
    checkOutput("rst_uv", 32'(bus.unit_valid), 32'h0);
    checkOutput("rst_cc", 32'(bus.cpu_complete), 32'h0);
    checkOutput("rst_result", bus.cpu_result, 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    waitCycle();

    $display("[TB] basic issue to unit 1");
    applyStimulus(1'b1, 11'h105, 32'h3F80_0000, 32'h4000_0000);
    for (int c = 1; c <= 6; c++) begin
      waitCycle();
      checkOutput($sformatf("t1_uv_c%0d", c), 32'(bus.unit_valid), (c <= 3) ? 32'h2 : 32'h0);
      checkOutput($sformatf("t1_cc_c%0d", c), 32'(bus.cpu_complete), 32'(c == 4));
      checkOutput($sformatf("t1_busy_c%0d", c), 32'(busy), 32'(c <= 5));
      if (c == 1 || c == 3) begin
        checkOutput("t1_opcode", 32'(bus.unit_opcode), 32'h105);
        checkOutput("t1_op0", bus.unit_op0, 32'h3F80_0000);
        checkOutput("t1_op1", bus.unit_op1, 32'h4000_0000);
      end
      if (c == 4) checkOutput("t1_result", bus.cpu_result, 32'h4040_0000);
      unitIdle();
      if (c == 3) unitDone(1, 32'h4040_0000);
      if (c == 5) bus.cpu_valid = 1'b0;
    end

    $display("[TB] bad select and err_clr");
    runBadSelect(11'h600, "t2");
    err_clr = 1'b1;
    waitCycle();
    err_clr = 1'b0;
    checkOutput("t2_err_cleared", 32'(err), 32'h0);

    err_clr = 1'b1;
    applyStimulus(1'b1, 11'h7FF, 32'h0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      waitCycle();
      checkOutput($sformatf("t2b_err_c%0d", c), 32'(err), (c == 2) ? 32'h1 : 32'h0);
      checkOutput($sformatf("t2b_cc_c%0d", c), 32'(bus.cpu_complete), 32'(c == 2));
      if (c == 3) begin
        err_clr       = 1'b0;
        bus.cpu_valid = 1'b0;
      end
    end

    $display("[TB] spurious completion, held valid, zero-latency unit");
    applyStimulus(1'b1, 11'h237, 32'hC0DE_0001, 32'hC0DE_0002);
    for (int c = 1; c <= 16; c++) begin
      waitCycle();
      checkOutput($sformatf("t3_uv_c%0d", c), 32'(bus.unit_valid),
                  ((c <= 4) || (c == 13)) ? 32'h4 : 32'h0);
      checkOutput($sformatf("t3_cc_c%0d", c), 32'(bus.cpu_complete), 32'((c == 5) || (c == 14)));
      checkOutput($sformatf("t3_busy_c%0d", c), 32'(busy), 32'(!((c == 12) || (c == 16))));
      if (c == 3) checkOutput("t3_result_untouched", bus.cpu_result, 32'h0);
      if (c == 5) checkOutput("t3_result", bus.cpu_result, 32'h1234_5678);
      if (c == 13) checkOutput("t3_op1_reissue", bus.unit_op1, 32'hC0DE_0004);
      if (c == 14) checkOutput("t3_result_zero_lat", bus.cpu_result, 32'h0BAD_F00D);
      unitIdle();
      if (c == 2) unitDone(0, 32'hDEAD_BEEF);
      if (c == 4) unitDone(2, 32'h1234_5678);
      if (c == 11) bus.cpu_valid = 1'b0;
      if (c == 12) applyStimulus(1'b1, 11'h2F0, 32'hC0DE_0003, 32'hC0DE_0004);
      if (c == 13) unitDone(2, 32'h0BAD_F00D);
      if (c == 15) bus.cpu_valid = 1'b0;
    end

    $display("[TB] reset mid-operation");
    runBadSelect(11'h500, "t5pre");
    applyStimulus(1'b1, 11'h3AA, 32'hAAAA_0000, 32'h5555_0000);
    for (int c = 1; c <= 12; c++) begin
      waitCycle();
      checkOutput($sformatf("t5_uv_c%0d", c), 32'(bus.unit_valid),
                  ((c == 1) || (c == 5) || (c == 6) || (c == 9)) ? 32'h8 : 32'h0);
      checkOutput($sformatf("t5_cc_c%0d", c), 32'(bus.cpu_complete), 32'((c == 2) || (c == 10)));
      checkOutput($sformatf("t5_busy_c%0d", c), 32'(busy),
                  32'(!((c == 4) || (c == 7) || (c == 8) || (c == 12))));
      if (c == 3) checkOutput("t5_result_a", bus.cpu_result, 32'h7777_0001);
      if (c == 7 || c == 8) begin
        checkOutput($sformatf("t5_rst_result_c%0d", c), bus.cpu_result, 32'h0);
        checkOutput($sformatf("t5_rst_opcode_c%0d", c), 32'(bus.unit_opcode), 32'h0);
        checkOutput($sformatf("t5_rst_op0_c%0d", c), bus.unit_op0, 32'h0);
        checkOutput($sformatf("t5_rst_op1_c%0d", c), bus.unit_op1, 32'h0);
        checkOutput($sformatf("t5_rst_err_c%0d", c), 32'(err), 32'h0);
      end
      if (c == 10) checkOutput("t5_result_c", bus.cpu_result, 32'h7777_0002);
      unitIdle();
      if (c == 1) unitDone(3, 32'h7777_0001);
      if (c == 2) bus.cpu_valid = 1'b0;
      if (c == 4) applyStimulus(1'b1, 11'h3C1, 32'hAAAA_0001, 32'h5555_0001);
      if (c == 6) begin
        rst           = 1'b1;
        bus.cpu_valid = 1'b0;
      end
      if (c == 7) begin
        rst = 1'b0;
        unitDone(3, 32'h9999_9999);
      end
      if (c == 8) applyStimulus(1'b1, 11'h3C2, 32'hAAAA_0002, 32'h5555_0002);
      if (c == 9) unitDone(3, 32'h7777_0002);
      if (c == 10) bus.cpu_valid = 1'b0;
    end

`ifdef COPRO_TIMEOUT_EN
    $display("[TB] watchdog expiry");
    applyStimulus(1'b1, 11'h0FF, 32'h1, 32'h2);
    for (int c = 1; c <= 19; c++) begin
      waitCycle();
      checkOutput($sformatf("t6_uv_c%0d", c), 32'(bus.unit_valid), (c <= 16) ? 32'h1 : 32'h0);
      checkOutput($sformatf("t6_cc_c%0d", c), 32'(bus.cpu_complete), 32'(c == 17));
      if (c == 17) begin
        checkOutput("t6_result", bus.cpu_result, 32'hFFFF_FFFF);
        checkOutput("t6_err", 32'(err), 32'h2);
        bus.cpu_valid = 1'b0;
      end
      if (c == 19) checkOutput("t6_busy_idle", 32'(busy), 32'h0);
    end
    err_clr = 1'b1;
    waitCycle();
    err_clr = 1'b0;
    checkOutput("t6_err_cleared", 32'(err), 32'h0);

    applyStimulus(1'b1, 11'h0FF, 32'h3, 32'h4);
    for (int c = 1; c <= 19; c++) begin
      waitCycle();
      checkOutput($sformatf("t6tie_uv_c%0d", c), 32'(bus.unit_valid), (c <= 16) ? 32'h1 : 32'h0);
      checkOutput($sformatf("t6tie_cc_c%0d", c), 32'(bus.cpu_complete), 32'(c == 17));
      if (c == 17) begin
        checkOutput("t6tie_result", bus.cpu_result, 32'h5A5A_5A5A);
        checkOutput("t6tie_err", 32'(err), 32'h0);
        bus.cpu_valid = 1'b0;
      end
      unitIdle();
      if (c == 16) unitDone(0, 32'h5A5A_5A5A);
    end
`else
    $display("[TB] long wait without watchdog");
    applyStimulus(1'b1, 11'h0FF, 32'h1, 32'h2);
    for (int c = 1; c <= 43; c++) begin
      waitCycle();
      checkOutput($sformatf("t6_uv_c%0d", c), 32'(bus.unit_valid), (c <= 40) ? 32'h1 : 32'h0);
      checkOutput($sformatf("t6_cc_c%0d", c), 32'(bus.cpu_complete), 32'(c == 41));
      checkOutput($sformatf("t6_err_c%0d", c), 32'(err), 32'h0);
      if (c == 41) begin
        checkOutput("t6_result", bus.cpu_result, 32'h5A5A_5A5A);
        bus.cpu_valid = 1'b0;
      end
      if (c == 43) checkOutput("t6_busy_idle", 32'(busy), 32'h0);
      unitIdle();
      if (c == 40) unitDone(0, 32'h5A5A_5A5A);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: observed simulation still running, expected summary");
    $fatal(1);
  end

endmodule
